led_frame_arbiter: RTL and testbench
====================================

LED_FRAME_ARBITER -- requirements
Module: led_frame_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of frame sources; fixed at 4 in this revision.
REQ-002 Parameter DWELL, default 1000, maximum grant tenure in clock cycles; SHALL be >= 1.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_SRC  per-source request for the display; level, held while source wants it.
REQ-006 src_en  input  NUM_SRC x 8  per-source digit enable masks, bit i = digit i lit.
REQ-007 src_display  input  NUM_SRC x 8 x 8  per-source segment patterns, one byte per digit.
REQ-008 grant  output  NUM_SRC  one-hot owner of the display; all-zero when idle.
REQ-009 en  output  8  enable mask forwarded to the scan multiplexer.
REQ-010 display  output  8 x 8  segment patterns forwarded to the scan multiplexer.
REQ-011 busy  output  1  high while any source holds a grant.

Function
REQ-012 The block SHALL have two states: IDLE (no owner) and HOLD (one owner, tenure counter running).
REQ-013 In IDLE with req != 0 at a rising edge, the block SHALL grant the first requester at or after position ptr in round-robin order (ptr, ptr+1, ... mod 4) and enter HOLD; grant SHALL be visible one cycle after req is sampled.
REQ-014 On entering HOLD, the tenure counter SHALL load DWELL-1 and decrement once per cycle while in HOLD.
REQ-015 The tenure SHALL end at the edge where the owner's req is low or the counter reads 0, whichever comes first.
REQ-016 At tenure end, the block SHALL re-arbitrate on the same edge, searching from owner+1 round-robin and considering the owner last; with no requester it SHALL enter IDLE.
REQ-017 If the owner is the only requester at counter expiry, it SHALL be re-granted with the counter reloaded to DWELL-1; grant SHALL not drop.
REQ-018 ptr SHALL update to (granted index + 1) mod 4 on every grant, including re-grants.
REQ-019 Requests from non-owners SHALL never pre-empt a tenure before REQ-015 conditions.
REQ-020 grant SHALL be one-hot or zero at all times; busy SHALL equal OR of grant.
REQ-021 en and display SHALL be combinational selections of src_en/src_display of the granted source; when grant is zero, en SHALL be 8'h00 and display all zeros.
REQ-022 Counter width SHALL be max(1, clog2(DWELL)) bits; no wrap below 0 permitted.
REQ-023 A req edge change of the owner in the same cycle as counter expiry SHALL be treated as one tenure end (no double advance of ptr).

Reset
REQ-024 While rst is high at a rising edge: state IDLE, grant 0, busy 0, counter 0, ptr 0; en and display therefore 0.
REQ-025 Reset asserted mid-tenure SHALL drop grant on the following edge regardless of req; the first grant after reset SHALL start search at source 0.

Structure
REQ-026 Package ledmon_pkg SHALL hold NUM_SRC, DIGITS = 8, typedef digit_t (8-bit segment byte), typedef frame_t (DIGITS x digit_t), and the state enum {IDLE, HOLD}.
REQ-027 One sub-module rr_pick SHALL implement the combinational round-robin search (inputs req vector, start index; outputs one-hot pick and valid).
REQ-028 The block SHALL contain no scan multiplexing; its en/display outputs connect directly to the existing 8-digit scan multiplexer.

Verification (DWELL = 4 for all)
REQ-029 rst high 2 cycles, req = 4'b0000 -> grant 0, busy 0, en 8'h00, display 0 throughout.
REQ-030 req = 4'b0100 from cycle 0, held -> grant = 4'b0100 from cycle 1, never drops (re-grant every 4 cycles), en = src_en[2].
REQ-031 req = 4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each for exactly 4 cycles, no idle gap.
REQ-032 req = 4'b0011, source 0 drops req after 2 cycles of tenure -> grant moves to 4'b0010 on that edge, holds 4 cycles.
REQ-033 req = 4'b1000 granted, rst pulsed 1 cycle at tenure cycle 2 with req = 4'b1001 -> grant 0 for that cycle, then 4'b0001 (search from 0).
REQ-034 req = 4'b0000 during HOLD owner release -> IDLE next cycle, en 8'h00, busy 0.

Source files
------------

// File: rtl/ledmon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ledmon_pkg                                                 |
// | Purpose : Shared constants, frame types and arbiter state encoding   |
// |           for the LED frame arbiter and its round-robin picker.      |
// | Contents: NUM_SRC, DIGITS, IDX_W, digit_t, frame_t, state_t,         |
// |           onehot_to_idx()                                            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package ledmon_pkg;

   localparam int NUM_SRC = 4;
   localparam int DIGITS  = 8;
   localparam int IDX_W   = $clog2(NUM_SRC);

   // One segment byte per digit, DIGITS bytes per frame.
   typedef logic [7:0]              digit_t;
   typedef digit_t [DIGITS-1:0]     frame_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Binary index of a one-hot vector; all-zero input yields index 0.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (oh[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick                                                    |
// | Purpose : Combinational round-robin search. Returns the first set    |
// |           bit of req at or after position start, wrapping modulo N.  |
// | Ports   : req   [N-1:0]  request vector                              |
// |           start [IW-1:0] first position examined                     |
// |           pick  [N-1:0]  one-hot winner (zero when nothing requests) |
// |           valid          at least one request present                |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_pick
   import ledmon_pkg::*;
#(
   parameter int N  = NUM_SRC,
   parameter int IW = IDX_W
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  pick,
   output logic          valid
);

   logic [IW-1:0] idx;
   logic          found;

   // N is a power of two, so the IW-bit addition wraps exactly modulo N.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = start + IW'(k);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/led_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_frame_arbiter                                          |
// | Purpose : Grants the 8-digit display to one of NUM_SRC frame sources |
// |           in round-robin order, each for at most DWELL cycles, and   |
// |           forwards the owner's enable mask and segment bytes to the  |
// |           scan multiplexer.                                          |
// | Ports   : clock, rst (sync, active-high)                             |
// |           req[NUM_SRC]            per-source level request           |
// |           src_en[NUM_SRC][8]      per-source digit enables           |
// |           src_display[NUM_SRC]    per-source frames                  |
// |           grant[NUM_SRC]          one-hot owner, zero when idle      |
// |           en[8], display          owner's selection, zero when idle  |
// |           busy                    any grant active                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module led_frame_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DWELL   = 1000
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            req,
   input  logic [NUM_SRC-1:0][7:0]       src_en,
   input  ledmon_pkg::frame_t [NUM_SRC-1:0] src_display,
   output logic [NUM_SRC-1:0]            grant,
   output logic [7:0]                    en,
   output ledmon_pkg::frame_t            display,
   output logic                          busy
);
   import ledmon_pkg::*;

   localparam int IW = $clog2(NUM_SRC);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

   state_t               state, state_n;
   logic [NUM_SRC-1:0]   grant_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [IW-1:0]        ptr, ptr_n;

   logic [NUM_SRC-1:0]   pick;
   logic                 pick_valid;
   logic [IW-1:0]        pick_idx;
   logic                 owner_req;
   logic                 tenure_end;

   // ptr always equals owner+1 while holding, so a single search starting
   // at ptr serves both the idle search and the re-arbitration that
   // considers the current owner last.
   rr_pick #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .start (ptr),
      .pick  (pick),
      .valid (pick_valid)
   );

   assign pick_idx   = onehot_to_idx(pick);
   assign owner_req  = |(req & grant);
   // Owner release and expiry on the same edge are one tenure end.
   assign tenure_end = !owner_req || (cnt == '0);

   always_ff @(posedge clock) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         cnt   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         cnt   <= cnt_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant;
      cnt_n   = cnt;
      ptr_n   = ptr;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_n = HOLD;
               grant_n = pick;
               cnt_n   = CNT_LOAD;
               ptr_n   = pick_idx + IW'(1);
            end
         end
         HOLD: begin
            if (tenure_end) begin
               if (pick_valid) begin
                  grant_n = pick;
                  cnt_n   = CNT_LOAD;
                  ptr_n   = pick_idx + IW'(1);
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            cnt_n   = '0;
         end
      endcase
   end

   // grant is one-hot or zero, so a priority-free select is sufficient.
   always_comb begin
      en      = '0;
      display = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            en      = src_en[i];
            display = src_display[i];
         end
      end
   end

   assign busy = |grant;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_led_frame_arbiter                                       |
// | Purpose : Self-checking bench for led_frame_arbiter with DWELL = 4:  |
// |           directed vector table followed by randomized traffic      |
// |           compared against a tenure/owner reference model.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_led_frame_arbiter;

   localparam int DWELL = 4;

   logic                        clock = 1'b0;
   logic                        rst;
   logic [3:0]                  req;
   logic [3:0][7:0]             src_en;
   ledmon_pkg::frame_t [3:0]    src_display;
   logic [3:0]                  grant;
   logic [7:0]                  en;
   ledmon_pkg::frame_t          display;
   logic                        busy;

   int errors = 0;
   int checks = 0;

   // Reference model: who owns the display, for how many cycles so far,
   // and where the next idle search starts.
   int m_owner = -1;
   int m_age   = 0;
   int m_ptr   = 0;

   typedef struct {
      logic       r;
      logic [3:0] q;
      logic [3:0] eg;
      string      tag;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   led_frame_arbiter #(
      .NUM_SRC (4),
      .DWELL   (DWELL)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .req         (req),
      .src_en      (src_en),
      .src_display (src_display),
      .grant       (grant),
      .en          (en),
      .display     (display),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic [3:0] q);
      int start;
      int found;
      int c;
      if (r) begin
         m_owner = -1;
         m_age   = 0;
         m_ptr   = 0;
      end else if (m_owner < 0 || !q[m_owner] || m_age == DWELL) begin
         start = (m_owner < 0) ? m_ptr : (m_owner + 1) % 4;
         found = -1;
         for (int k = 0; k < 4; k++) begin
            c = (start + k) % 4;
            if (found < 0 && q[c]) found = c;
         end
         m_owner = found;
         if (found >= 0) begin
            m_age = 1;
            m_ptr = (found + 1) % 4;
         end else begin
            m_age = 0;
         end
      end else begin
         m_age++;
      end
   endtask

   function automatic logic [3:0] model_grant();
      logic [3:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic check_outputs(input logic [3:0] eg, input string tag);
      logic [7:0]         e_en;
      ledmon_pkg::frame_t e_disp;
      e_en   = '0;
      e_disp = '0;
      for (int i = 0; i < 4; i++) begin
         if (eg[i]) begin
            e_en   = src_en[i];
            e_disp = src_display[i];
         end
      end
      chk({tag, ".grant"},   64'(grant),   64'(eg));
      chk({tag, ".busy"},    64'(busy),    64'(|eg));
      chk({tag, ".en"},      64'(en),      64'(e_en));
      chk({tag, ".display"}, 64'(display), 64'(e_disp));
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic [3:0] eg,
                      input int n, input string tag);
      for (int i = 0; i < n; i++) vecs.push_back('{r, q, eg, tag});
   endtask

   task automatic step(input logic r, input logic [3:0] q);
      rst = r;
      req = q;
      @(posedge clock);
      model_edge(r, q);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         src_en[i] = 8'(8'h11 * (i + 1));
         for (int d = 0; d < 8; d++) src_display[i][d] = 8'((i << 4) | d | 8'h80);
      end

      // Reset with no requests, then idle.
      add(1'b1, 4'b0000, 4'b0000, 2, "reset");
      add(1'b0, 4'b0000, 4'b0000, 1, "idle");
      // Single held requester keeps the display across expiries.
      add(1'b0, 4'b0100, 4'b0100, 10, "solo");
      add(1'b0, 4'b0000, 4'b0000, 2, "release");
      // Full contention from ptr 0: four cycles each, no gap.
      add(1'b1, 4'b0000, 4'b0000, 1, "rst_c");
      add(1'b0, 4'b1111, 4'b0001, 4, "rr0");
      add(1'b0, 4'b1111, 4'b0010, 4, "rr1");
      add(1'b0, 4'b1111, 4'b0100, 4, "rr2");
      add(1'b0, 4'b1111, 4'b1000, 4, "rr3");
      add(1'b0, 4'b1111, 4'b0001, 1, "rr_wrap");
      // Owner drops mid-tenure.
      add(1'b1, 4'b0000, 4'b0000, 1, "rst_d");
      add(1'b0, 4'b0011, 4'b0001, 2, "drop_own");
      add(1'b0, 4'b0010, 4'b0010, 5, "drop_next");
      // Reset mid-tenure, then search restarts at source 0.
      add(1'b1, 4'b0000, 4'b0000, 1, "rst_e");
      add(1'b0, 4'b1000, 4'b1000, 2, "pre_rst");
      add(1'b1, 4'b1001, 4'b0000, 1, "mid_rst");
      add(1'b0, 4'b1001, 4'b0001, 4, "post_rst");
      add(1'b0, 4'b1001, 4'b1000, 1, "post_rst_next");
      // Owner releases on its expiry edge: one advance only.
      add(1'b1, 4'b0000, 4'b0000, 1, "rst_f");
      add(1'b0, 4'b0110, 4'b0010, 4, "exp_own");
      add(1'b0, 4'b0100, 4'b0100, 1, "exp_drop");
      add(1'b0, 4'b1100, 4'b0100, 3, "exp_hold");
      add(1'b0, 4'b1100, 4'b1000, 1, "exp_next");
      add(1'b0, 4'b0000, 4'b0000, 1, "exp_idle");

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].q);
         check_outputs(vecs[i].eg, vecs[i].tag);
      end

      // Randomized traffic against the reference model.
      step(1'b1, 4'b0000);
      check_outputs(model_grant(), "rand_rst");
      for (int n = 0; n < 3000; n++) begin
         logic       r;
         logic [3:0] q;
         r = ($urandom_range(0, 79) == 0);
         q = req;
         if ($urandom_range(0, 3) == 0) q = 4'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            for (int i = 0; i < 4; i++) begin
               src_en[i] = 8'($urandom);
               for (int d = 0; d < 8; d++) src_display[i][d] = 8'($urandom);
            end
         end
         step(r, q);
         check_outputs(model_grant(), "rand");
         chk("rand.onehot", 64'($onehot0(grant)), 64'(1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
